// File: rtl/serial_mirror_fifo.sv
// Buffered UART echo engine: transforms received bytes into a FIFO and drains
// it through the UART transmit handshake, with optional CR -> CR LF expansion.
module serial_mirror_fifo #(
    parameter int ADDR_W     = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clki,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  is_transmitting,
    input  logic [1:0]            mode,
    input  logic                  crlf_en,
    input  logic                  clear_status,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    output logic [ADDR_W:0]       level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int                    DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]       LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]     PTR_ONE = ADDR_W'(1);
    localparam logic [DROP_CNT_W-1:0] CNT_ONE = DROP_CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]       level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    state_t                state_q;
    logic                  transmit_q, pending_lf_q;
    logic [7:0]            tx_byte_q;

    logic       accept, full, wr_en, drop, pop;
    logic [7:0] head, wdata;

    function automatic logic [7:0] xform(input logic [1:0] m, input logic [7:0] b);
        xform = b;
        if (m == 2'b01 && b >= 8'h61 && b <= 8'h7A)
            xform = b - 8'h20;
        else if (m == 2'b10 && b >= 8'h41 && b <= 8'h5A)
            xform = b + 8'h20;
    endfunction

    // A full FIFO drops the byte even if the FSM pops in the same cycle.
    always_comb begin
        accept = received && (mode != 2'b11);
        full   = (level_q == DEPTH_L);
        wr_en  = accept && !full;
        drop   = accept && full;
        pop    = (state_q == S_IDLE) && (level_q != '0);
        head   = mem_q[rd_ptr_q];
        wdata  = xform(mode, rx_byte);

        level_d = level_q;
        if (wr_en && !pop)
            level_d = level_q + LVL_ONE;
        else if (!wr_en && pop)
            level_d = level_q - LVL_ONE;

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_status)
                drop_cnt_d = CNT_ONE;
            else if (drop_cnt_q != '1)
                drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else if (clear_status) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clki) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // The inserted LF never touches the FIFO; it is replayed from BUSY.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            transmit_q   <= 1'b0;
            tx_byte_q    <= '0;
            pending_lf_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_byte_q    <= head;
                        transmit_q   <= 1'b1;
                        pending_lf_q <= crlf_en && (head == 8'h0D);
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (is_transmitting) begin
                        transmit_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!is_transmitting) begin
                        if (pending_lf_q) begin
                            tx_byte_q    <= 8'h0A;
                            transmit_q   <= 1'b1;
                            pending_lf_q <= 1'b0;
                            state_q      <= S_REQ;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign transmit   = transmit_q;
    assign tx_byte    = tx_byte_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_serial_mirror_fifo.sv
// Bench for serial_mirror_fifo: UART model captures the transmitted stream,
// which is compared against byte streams derived from the echo rules.
module tb_serial_mirror_fifo;

    localparam int AW = 2;
    localparam int DW = 3;
    localparam int K  = 3;

    logic          clki = 1'b0;
    logic          rst, received, is_transmitting, crlf_en, clear_status;
    logic [7:0]    rx_byte, tx_byte;
    logic [1:0]    mode;
    logic          transmit, overflow;
    logic [AW:0]   level;
    logic [DW-1:0] drop_count;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] cap[$];
    int         cnt = 0;
    int         max_lvl = 0;
    bit         hold = 1'b0;
    bit         mute = 1'b0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] rx;
        logic       has_tx;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[13];

    always #5 clki = ~clki;

    serial_mirror_fifo #(.ADDR_W(AW), .DROP_CNT_W(DW)) dut (
        .clki(clki), .rst(rst), .received(received), .rx_byte(rx_byte),
        .is_transmitting(is_transmitting), .mode(mode), .crlf_en(crlf_en),
        .clear_status(clear_status), .transmit(transmit), .tx_byte(tx_byte),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    // UART model: accepts a request when idle, busy for K cycles; hold forces busy.
    initial begin
        is_transmitting = 1'b0;
        forever begin
            @(negedge clki);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (cnt > 0) cnt--;
            if (!mute && transmit === 1'b1 && cnt == 0) begin
                cap.push_back(tx_byte);
                cnt = K;
            end
            is_transmitting = hold || (cnt > 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    function automatic logic [7:0] ref_xf(input logic [1:0] m, input logic [7:0] b);
        if (m == 2'd1 && b inside {[8'h61:8'h7A]}) return b - 8'h20;
        if (m == 2'd2 && b inside {[8'h41:8'h5A]}) return b + 8'h20;
        return b;
    endfunction

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] m);
        mode = m; rx_byte = b; received = 1'b1;
        tick();
        received = 1'b0;
    endtask

    task automatic drain(input int n);
        int t;
        t = 0;
        while (!(cap.size() >= n && cnt == 0 && transmit == 1'b0 && !hold) && t < 300) begin
            tick();
            t++;
        end
        chk("drain_done", 32'(t < 300), 1);
        tick();
        tick();
    endtask

    task automatic cmp_stream(input string nm, input int base, input logic [7:0] exp[$]);
        chk({nm, "_count"}, cap.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (base + i < cap.size())
                chk($sformatf("%s_byte%0d", nm, i), cap[base+i], exp[i]);
    endtask

    initial begin
        int         base, len;
        logic [1:0] m;
        logic [7:0] b, t;
        logic [7:0] expq[$];

        tbl[0]  = '{2'd0, 8'h41, 1'b1, 8'h41};
        tbl[1]  = '{2'd0, 8'h7A, 1'b1, 8'h7A};
        tbl[2]  = '{2'd1, 8'h61, 1'b1, 8'h41};
        tbl[3]  = '{2'd1, 8'h7A, 1'b1, 8'h5A};
        tbl[4]  = '{2'd1, 8'h60, 1'b1, 8'h60};
        tbl[5]  = '{2'd1, 8'h7B, 1'b1, 8'h7B};
        tbl[6]  = '{2'd1, 8'h5A, 1'b1, 8'h5A};
        tbl[7]  = '{2'd2, 8'h41, 1'b1, 8'h61};
        tbl[8]  = '{2'd2, 8'h5A, 1'b1, 8'h7A};
        tbl[9]  = '{2'd2, 8'h40, 1'b1, 8'h40};
        tbl[10] = '{2'd2, 8'h5B, 1'b1, 8'h5B};
        tbl[11] = '{2'd2, 8'h31, 1'b1, 8'h31};
        tbl[12] = '{2'd3, 8'h41, 1'b0, 8'h00};

        rst = 1'b0; received = 1'b0; rx_byte = '0; mode = '0;
        crlf_en = 1'b0; clear_status = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_transmit", transmit, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Echo latency: transmit appears after the second edge following the pulse.
        base = cap.size();
        mode = 2'd0; rx_byte = 8'h41; received = 1'b1;
        @(negedge clki);
        chk("lat_t0_transmit", transmit, 0);
        tick();
        rx_byte = 8'h7A;
        @(negedge clki);
        chk("lat_t1_transmit", transmit, 0);
        chk("lat_t1_level", level, 1);
        tick();
        received = 1'b0;
        @(negedge clki);
        chk("lat_t2_transmit", transmit, 1);
        chk("lat_t2_tx_byte", tx_byte, 8'h41);
        drain(base + 2);
        expq = '{8'h41, 8'h7A};
        cmp_stream("echo", base, expq);
        chk("echo_level", level, 0);

        for (int i = 0; i < 13; i++) begin
            base = cap.size();
            send(tbl[i].rx, tbl[i].mode);
            drain(base + int'(tbl[i].has_tx));
            chk($sformatf("tbl%0d_count", i), cap.size() - base, 32'(tbl[i].has_tx));
            if (tbl[i].has_tx && cap.size() > base)
                chk($sformatf("tbl%0d_byte", i), cap[base], tbl[i].exp);
        end
        chk("tbl_level", level, 0);

        base = cap.size();
        send(8'h61, 2'd1); send(8'h5A, 2'd1); send(8'h31, 2'd1); send(8'h41, 2'd2);
        drain(base + 4);
        expq = '{8'h41, 8'h5A, 8'h31, 8'h61};
        cmp_stream("xform", base, expq);

        crlf_en = 1'b1;
        max_lvl = 0;
        base = cap.size();
        send(8'h68, 2'd0); send(8'h0D, 2'd0);
        drain(base + 3);
        expq = '{8'h68, 8'h0D, 8'h0A};
        cmp_stream("crlf", base, expq);
        chk("crlf_maxlvl", 32'(max_lvl <= 2), 1);
        chk("crlf_level", level, 0);

        for (int r = 0; r < 25; r++) begin
            base = cap.size();
            expq.delete();
            len = $urandom_range(1, 4);
            crlf_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                m = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: b = 8'h0D;
                    1: b = 8'h41 + 8'($urandom_range(0, 25));
                    2: b = 8'h61 + 8'($urandom_range(0, 25));
                    default: b = 8'($urandom);
                endcase
                if (m != 2'd3) begin
                    t = ref_xf(m, b);
                    expq.push_back(t);
                    if (crlf_en && t == 8'h0D) expq.push_back(8'h0A);
                end
                send(b, m);
            end
            drain(base + expq.size());
            cmp_stream($sformatf("rand%0d", r), base, expq);
            chk("rand_level", level, 0);
            chk("rand_overflow", overflow, 0);
        end

        // Overflow with the UART held busy: 1 in flight, 4 buffered, 2 dropped.
        crlf_en = 1'b0;
        hold = 1'b1;
        tick(); tick();
        base = cap.size();
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 2'd0);
        @(negedge clki);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_count, 2);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        @(negedge clki);
        chk("clr_flag", overflow, 0);
        chk("clr_drop", drop_count, 0);
        chk("clr_level", level, 4);
        clear_status = 1'b1;
        send(8'h30, 2'd0);
        clear_status = 1'b0;
        @(negedge clki);
        chk("clrdrop_flag", overflow, 1);
        chk("clrdrop_drop", drop_count, 1);
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 2'd0);
        @(negedge clki);
        chk("sat_drop", drop_count, 7);
        chk("sat_level", level, 4);
        tick();
        hold = 1'b0;
        drain(base + 5);
        expq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        cmp_stream("ovf", base, expq);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_drop_sticky", drop_count, 7);

        // Reset while stuck in REQ with three bytes buffered.
        mute = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), 2'd0);
        @(negedge clki);
        chk("pre_rst_transmit", transmit, 1);
        chk("pre_rst_level", level, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_transmit", transmit, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_tx_byte", tx_byte, 0);
        tick(); tick();
        rst = 1'b0;
        mute = 1'b0;
        base = cap.size();
        repeat (20) tick();
        chk("post_rst_quiet", cap.size() - base, 0);
        chk("post_rst_transmit", transmit, 0);
        send(8'h55, 2'd0);
        drain(base + 1);
        expq = '{8'h55};
        cmp_stream("post_rst", base, expq);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
